fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin arbiter that shares one FIFO write port between NUM_REQ valid/ready producers.
//  Sits in front of the write side of the AXI-to-FIFO bridge's FIFO.
//  Grants one producer at a time for a burst of up to MAX_BURST words, so producers never interleave inside a burst.
//  Stalls cleanly on fifo_full.
// PARAMETERS
//  NUM_REQ     4   number of producers, 2..16
//  DATA_WIDTH  32  word width, matches the FIFO width
//  MAX_BURST   4   max words per grant, >=1
// PORTS
//  aclk          in   1                    clock; everything is synchronous to its rising edge
//  aresetn       in   1                    reset, asynchronous assert, active-low
//  req_data      in   NUM_REQ*DATA_WIDTH   producer words; producer i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_valid     in   NUM_REQ              producer i has a word
//  req_ready     out  NUM_REQ              word accepted from producer i this cycle
//  fifo_wr_data  out  DATA_WIDTH           word to the FIFO
//  fifo_wr_en    out  1                    FIFO write strobe
//  fifo_full     in   1                    FIFO cannot accept a word
//  grant_active  out  1                    a burst grant is held
//  grant_idx     out  clog2(NUM_REQ)       index of the granted producer
// BEHAVIOUR
//  - Reset (aresetn=0, asynchronous), applied immediately:
//    state=IDLE; grant_idx=0; rr_ptr=NUM_REQ-1; burst_cnt=0; grant_active=0.
//    All req_ready=0 and fifo_wr_en=0, because both are gated by state.
//  - FSM has two states, IDLE and GRANT.
//    - IDLE: when any req_valid=1, pick the first i with req_valid[i]=1, scanning from rr_ptr+1 and wrapping modulo NUM_REQ.
//      Next edge: grant_idx<=i, rr_ptr<=i, burst_cnt<=0, state<=GRANT.
//      No word is transferred in IDLE, so every grant costs one arbitration bubble.
//    - GRANT, combinational:
//      - req_ready[grant_idx] = !fifo_full; all other req_ready = 0.
//      - xfer = req_valid[grant_idx] & req_ready[grant_idx].
//      - fifo_wr_en = xfer; fifo_wr_data = slice grant_idx of req_data.
//    - GRANT, sequential:
//      - xfer: burst_cnt++.
//      - Return to IDLE when either holds:
//        - xfer and burst_cnt==MAX_BURST-1 (burst complete), or
//        - req_valid[grant_idx]=0 (producer idle; grant released, no word taken that cycle).
//  - fifo_full=1 in GRANT: no transfer, grant held and burst_cnt unchanged; the burst resumes when full clears.
//    Full alone never releases a grant.
//  - MAX_BURST=1: exactly one word per grant.
//  - burst_cnt width is clog2(MAX_BURST+1) and never exceeds MAX_BURST-1.
//  - grant_active = (state==GRANT), registered.
//  - A producer holding valid with fifo_full low gets MAX_BURST words per round.
//  - Worst-case wait for a requester is (NUM_REQ-1)*(MAX_BURST+1) cycles while the FIFO is not full.
//  - Reset asserted mid-burst: outputs drop in the same cycle. A partly sent burst is not resumed.
//    After release, arbitration restarts with requester 0 first.
// CONFIGURATION
//  FIFO_ARB_PRIORITY_EN
//   - Defined: in IDLE, req_valid[0]=1 always wins.
//     A priority grant of producer 0 leaves rr_ptr unchanged.
//     Other producers are served round-robin only when req_valid[0]=0.
//     Producer 0 can starve the others; this is intended, for the control/command channel.
//   - Undefined: pure round-robin as above; producer 0 has no special treatment.
// TESTING
//  1. Reset held with all req_valid=1 -> req_ready=0, fifo_wr_en=0, grant_active=0, grant_idx=0.
//  2. NUM_REQ=4, MAX_BURST=4; producers 0,1,2 valid and streaming, fifo_full=0
//     -> FIFO gets 4 words from 0, 4 from 1, 4 from 2, then 0 again; one idle cycle between bursts.
//  3. Burst to producer 1, fifo_full=1 for 3 cycles after word 2
//     -> req_ready[1]=0 and fifo_wr_en=0 for 3 cycles; grant_idx stays 1; exactly 4 words total.
//  4. Producer 2 drops valid after 2 words, producer 3 valid
//     -> grant released after 2 words; next grant_idx=3 after one IDLE cycle.
//  5. aresetn pulled low mid-burst -> fifo_wr_en and req_ready are 0 that cycle.
//     After release, with all producers valid, producer 0 is granted first.
//  6. Producers 0 and 2 always valid
//     -> with FIFO_ARB_PRIORITY_EN defined: only producer 0 is ever granted.
//     -> without it: grants alternate 0, 2, 0, 2.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready
// producers. A grant is held for a burst of up to MAX_BURST words, so words
// from different producers never interleave inside a burst. fifo_full stalls
// the burst without releasing the grant.
//
// Optional feature macro: FIFO_ARB_PRIORITY_EN
//   Defined   : producer 0 wins every arbitration in which it is valid and
//               leaves the round-robin pointer untouched (command channel).
//   Undefined : pure round-robin, producer 0 is not treated specially.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  output logic                          grant_active,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               grant_active_q;

  logic               pick_found;
  logic               pick_prio;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic               xfer;

  // Select the valid bit and data word of the currently granted producer.
  always_comb begin
    sel_valid = req_valid[grant_idx_q];
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration: first valid producer scanning from rr_ptr+1 with wrap.
  always_comb begin
    pick_found = 1'b0;
    pick_prio  = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
`ifdef FIFO_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      pick_prio = 1'b1;
      pick_idx  = '0;
    end
`else
    pick_prio = 1'b0;
`endif
  end

  // State and grant bookkeeping registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      grant_idx_q    <= '0;
      rr_ptr_q       <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q    <= '0;
      grant_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_idx_q    <= grant_idx_d;
      rr_ptr_q       <= rr_ptr_d;
      burst_cnt_q    <= burst_cnt_d;
      grant_active_q <= (state_d == GRANT);
    end
  end

  // Next-state logic: grant on any request, release on burst end or idle producer.
  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_idx_d = pick_idx;
          burst_cnt_d = '0;
          if (!pick_prio) begin
            rr_ptr_d = pick_idx;
          end
        end
      end
      GRANT: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (xfer) begin
          if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshake and FIFO write only while a grant is held.
  always_comb begin
    req_ready    = '0;
    xfer         = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = sel_data;
    if (state_q == GRANT) begin
      req_ready[grant_idx_q] = !fifo_full;
      xfer                   = sel_valid && !fifo_full;
      fifo_wr_en             = xfer;
    end
  end

  assign grant_active = grant_active_q;
  assign grant_idx    = grant_idx_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
// Producer i presents word {i[7:0], seq_i[23:0]}; seq_i advances on each
// accepted handshake. Expectations follow the FIFO_ARB_PRIORITY_EN setting.
module tb_fifo_write_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;

  logic          aclk;
  logic          aresetn;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [DW-1:0] fifo_wr_data;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          grant_active;
  logic [1:0]    grant_idx;

  int n_chk = 0;
  int n_err = 0;
  int seq [NR];
  int start_seq;

  fifo_write_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_full    (fifo_full),
    .grant_active (grant_active),
    .grant_idx    (grant_idx)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
    end
  endtask

  // Advance one clock: account accepted words, then settle new inputs.
  task automatic tick();
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) seq[i]++;
    end
    @(posedge aclk);
    #1;
    drive();
    #1;
  endtask

  // src < 0: arbitration bubble expected; otherwise a write from producer src.
  task automatic expect_cycle(input string tag, input int src);
    if (src < 0) begin
      chk({tag, ".bub_wr_en"}, 32'(fifo_wr_en), 32'd0);
      chk({tag, ".bub_active"}, 32'(grant_active), 32'd0);
      chk({tag, ".bub_ready"}, 32'(req_ready), 32'd0);
    end else begin
      chk({tag, ".active"}, 32'(grant_active), 32'd1);
      chk({tag, ".idx"}, 32'(grant_idx), 32'(src));
      chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'd1);
      chk({tag, ".ready"}, 32'(req_ready), 32'd1 << src);
      chk({tag, ".data"}, fifo_wr_data, {8'(src), 24'(seq[src])});
    end
  endtask

  task automatic run_table(input string tag, input int tbl [20]);
    for (int c = 0; c < 20; c++) begin
      tick();
      expect_cycle($sformatf("%s[%0d]", tag, c), tbl[c]);
    end
  endtask

`ifdef FIFO_ARB_PRIORITY_EN
  int t2 [20] = '{0,0,0,0,-1, 0,0,0,0,-1, 0,0,0,0,-1, 0,0,0,0,-1};
  int t6 [20] = '{0,0,0,0,-1, 0,0,0,0,-1, 0,0,0,0,-1, 0,0,0,0,-1};
`else
  int t2 [20] = '{0,0,0,0,-1, 1,1,1,1,-1, 2,2,2,2,-1, 0,0,0,0,-1};
  int t6 [20] = '{0,0,0,0,-1, 2,2,2,2,-1, 0,0,0,0,-1, 2,2,2,2,-1};
`endif

  initial begin
    for (int i = 0; i < NR; i++) seq[i] = 0;
    req_data  = '0;
    aresetn   = 1'b0;
    req_valid = 4'b1111;
    fifo_full = 1'b0;
    drive();
    #1;
    // 1: reset held with every producer requesting
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst.active", 32'(grant_active), 32'd0);
    chk("rst.idx", 32'(grant_idx), 32'd0);
    tick();
    tick();
    chk("rst_clk.ready", 32'(req_ready), 32'd0);
    chk("rst_clk.active", 32'(grant_active), 32'd0);

    // 2: producers 0,1,2 streaming
    req_valid = 4'b0111;
    aresetn   = 1'b1;
    #1;
    run_table("rr3", t2);

    // 3: producer 1 burst with fifo_full for 3 cycles after word 2
    req_valid = 4'b0010;
    #1;
    start_seq = seq[1];
    tick();
    expect_cycle("full.w1", 1);
    tick();
    expect_cycle("full.w2", 1);
    for (int s = 0; s < 3; s++) begin
      tick();
      if (s == 0) begin
        fifo_full = 1'b1;
        #1;
      end
      chk($sformatf("full.stall%0d.wr_en", s), 32'(fifo_wr_en), 32'd0);
      chk($sformatf("full.stall%0d.ready", s), 32'(req_ready), 32'd0);
      chk($sformatf("full.stall%0d.idx", s), 32'(grant_idx), 32'd1);
      chk($sformatf("full.stall%0d.active", s), 32'(grant_active), 32'd1);
    end
    fifo_full = 1'b0;
    #1;
    expect_cycle("full.w3", 1);
    tick();
    expect_cycle("full.w4", 1);
    tick();
    expect_cycle("full.end", -1);
    chk("full.words", 32'(seq[1] - start_seq), 32'd4);

    // 4: producer 2 drops valid after 2 words, producer 3 waiting
    req_valid = 4'b1100;
    #1;
    tick();
    expect_cycle("drop.w1", 2);
    tick();
    expect_cycle("drop.w2", 2);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("drop.wr_en", 32'(fifo_wr_en), 32'd0);
    chk("drop.idx", 32'(grant_idx), 32'd2);
    chk("drop.ready", 32'(req_ready), 32'b0100);
    tick();
    expect_cycle("drop.bubble", -1);
    tick();
    expect_cycle("drop.next", 3);
    req_valid = 4'b0000;
    #1;
    chk("drop.idle_wr_en", 32'(fifo_wr_en), 32'd0);
    tick();
    expect_cycle("drop.end", -1);

    // 5: reset asserted mid-burst, then all producers valid
    req_valid = 4'b0010;
    #1;
    tick();
    expect_cycle("mid.w1", 1);
    tick();
    expect_cycle("mid.w2", 1);
    req_valid = 4'b1111;
    aresetn   = 1'b0;
    #1;
    chk("mid.wr_en", 32'(fifo_wr_en), 32'd0);
    chk("mid.ready", 32'(req_ready), 32'd0);
    chk("mid.active", 32'(grant_active), 32'd0);
    chk("mid.idx", 32'(grant_idx), 32'd0);
    tick();
    tick();
    aresetn = 1'b1;
    #1;
    tick();
    expect_cycle("mid.first", 0);
    req_valid = 4'b0000;
    #1;
    tick();
    expect_cycle("mid.end", -1);

    // 6: producers 0 and 2 always valid, from a fresh reset
    aresetn = 1'b0;
    #1;
    tick();
    aresetn   = 1'b1;
    req_valid = 4'b0101;
    #1;
    run_table("p02", t6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
